// File: rtl/retire_rf.sv
// retire_rf: 32x64 architectural register file written by COMMIT_WIDTH retire
// lanes, with RPORTS combinational read ports (same-cycle bypass) and a 64-bit
// retired-instruction counter. Defining RETIRE_TRACE_EN adds a retired-PC
// trace queue with its handshake and sticky overflow flag.
module retire_rf #(
   parameter int unsigned COMMIT_WIDTH = 4,
   parameter int unsigned RPORTS       = 8,
   parameter int unsigned TRACE_DEPTH  = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [COMMIT_WIDTH-1:0]    commit_valid,
   input  logic [COMMIT_WIDTH*64-1:0] commit_pc,
   input  logic [COMMIT_WIDTH-1:0]    commit_wen,
   input  logic [COMMIT_WIDTH*5-1:0]  commit_rd,
   input  logic [COMMIT_WIDTH*64-1:0] commit_wdata,
   input  logic [RPORTS*5-1:0]        rd_addr,
   output logic [RPORTS*64-1:0]       rd_data,
   output logic [63:0]                instret
`ifdef RETIRE_TRACE_EN
   ,
   output logic                       trace_valid,
   output logic [63:0]                trace_pc,
   input  logic                       trace_ready,
   output logic                       trace_overflow
`endif
);
   localparam int unsigned CNTW = $clog2(COMMIT_WIDTH + 1);

   logic [63:0]             rf [32];
   logic [COMMIT_WIDTH-1:0] wr_qual;
   logic [CNTW-1:0]         retire_cnt;

   // Qualify write lanes (x0 never written) and count retiring lanes
   always_comb begin
      wr_qual    = '0;
      retire_cnt = '0;
      for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
         wr_qual[i] = commit_valid[i] && commit_wen[i] && (commit_rd[i*5 +: 5] != 5'd0);
         retire_cnt = retire_cnt + CNTW'(commit_valid[i]);
      end
   end

   // Register file update; ascending lane order lets the highest lane win a shared rd
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned r = 0; r < 32; r++) rf[r] <= '0;
      end else begin
         for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
            if (wr_qual[i]) rf[commit_rd[i*5 +: 5]] <= commit_wdata[i*64 +: 64];
         end
      end
   end

   // Read ports with same-cycle bypass; bypass is suppressed while reset is held
   always_comb begin
      rd_data = '0;
      for (int unsigned p = 0; p < RPORTS; p++) begin
         rd_data[p*64 +: 64] = rf[rd_addr[p*5 +: 5]];
         for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
            if (reset && wr_qual[i] && (commit_rd[i*5 +: 5] == rd_addr[p*5 +: 5]))
               rd_data[p*64 +: 64] = commit_wdata[i*64 +: 64];
         end
      end
   end

   // Retired-instruction counter, wraps modulo 2^64
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) instret <= '0;
      else        instret <= instret + 64'(retire_cnt);
   end

`ifdef RETIRE_TRACE_EN
   localparam int unsigned PTRW = $clog2(TRACE_DEPTH);

   logic [63:0]     tq [TRACE_DEPTH];
   logic [PTRW:0]   head, tail, occ, free_slots;
   logic [CNTW-1:0] lane_off [COMMIT_WIDTH];
   logic [CNTW-1:0] acc;
   logic            push_ok, push_drop, pop;

   // Occupancy from start-of-cycle pointers, all-or-nothing admission, slot offsets
   always_comb begin
      occ         = tail - head;
      free_slots  = (PTRW+1)'(TRACE_DEPTH) - occ;
      trace_valid = (occ != '0);
      trace_pc    = trace_valid ? tq[head[PTRW-1:0]] : '0;
      pop         = trace_valid && trace_ready;
      push_drop   = (PTRW+1)'(retire_cnt) > free_slots;
      push_ok     = (retire_cnt != '0) && !push_drop;
      acc         = '0;
      for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
         lane_off[i] = acc;
         acc         = acc + CNTW'(commit_valid[i]);
      end
   end

   // Queue storage, pointers and sticky overflow
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head           <= '0;
         tail           <= '0;
         trace_overflow <= 1'b0;
         for (int unsigned k = 0; k < TRACE_DEPTH; k++) tq[k] <= '0;
      end else begin
         if (pop) head <= head + (PTRW+1)'(1);
         if (push_ok) begin
            for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
               if (commit_valid[i])
                  tq[tail[PTRW-1:0] + PTRW'(lane_off[i])] <= commit_pc[i*64 +: 64];
            end
            tail <= tail + (PTRW+1)'(retire_cnt);
         end
         if (push_drop) trace_overflow <= 1'b1;
      end
   end
`else
   logic unused_pc;
   assign unused_pc = ^commit_pc;
`endif

endmodule

// File: tb/tb_retire_rf.sv
// Self-checking bench for retire_rf: register-file model and trace-queue
// scoreboard; trace scenarios are compiled only when RETIRE_TRACE_EN is defined.
module tb_retire_rf;
   localparam int CW = 4;
   localparam int RP = 8;
   localparam int TD = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic [CW-1:0]   commit_valid;
   logic [CW*64-1:0] commit_pc;
   logic [CW-1:0]   commit_wen;
   logic [CW*5-1:0] commit_rd;
   logic [CW*64-1:0] commit_wdata;
   logic [RP*5-1:0] rd_addr;
   logic [RP*64-1:0] rd_data;
   logic [63:0]     instret;
`ifdef RETIRE_TRACE_EN
   logic            trace_valid;
   logic [63:0]     trace_pc;
   logic            trace_ready;
   logic            trace_overflow;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] m_rf [32];
   logic [63:0] m_instret;
   logic        m_ovf;
   logic [63:0] exp_q [$];
   logic [63:0] trace_q [$];

   retire_rf #(.COMMIT_WIDTH(CW), .RPORTS(RP), .TRACE_DEPTH(TD)) dut (
      .clk(clk),
      .reset(reset),
      .commit_valid(commit_valid),
      .commit_pc(commit_pc),
      .commit_wen(commit_wen),
      .commit_rd(commit_rd),
      .commit_wdata(commit_wdata),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .instret(instret)
`ifdef RETIRE_TRACE_EN
      ,
      .trace_valid(trace_valid),
      .trace_pc(trace_pc),
      .trace_ready(trace_ready),
      .trace_overflow(trace_overflow)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic clear_commit();
      commit_valid = '0;
      commit_pc    = '0;
      commit_wen   = '0;
      commit_rd    = '0;
      commit_wdata = '0;
   endtask

   task automatic set_lane(input int l, input logic [4:0] rd, input logic [63:0] d,
                           input logic w, input logic [63:0] pc);
      commit_valid[l]         = 1'b1;
      commit_wen[l]           = w;
      commit_rd[l*5 +: 5]     = rd;
      commit_wdata[l*64 +: 64] = d;
      commit_pc[l*64 +: 64]   = pc;
   endtask

   function automatic logic [63:0] model_read(input logic [4:0] a);
      logic [63:0] v;
      v = m_rf[a];
      for (int i = 0; i < CW; i++)
         if (commit_valid[i] && commit_wen[i] && commit_rd[i*5 +: 5] == a && a != 5'd0)
            v = commit_wdata[i*64 +: 64];
      return v;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 32; r++) m_rf[r] = '0;
      m_instret = '0;
      m_ovf     = 1'b0;
      trace_q.delete();
      exp_q.delete();
   endtask

   // Apply this cycle's commit inputs to the model (called before the rising edge)
   task automatic model_commit();
      int cnt = 0;
      for (int i = 0; i < CW; i++) begin
         if (commit_valid[i]) cnt++;
         if (commit_valid[i] && commit_wen[i] && commit_rd[i*5 +: 5] != 5'd0)
            m_rf[commit_rd[i*5 +: 5]] = commit_wdata[i*64 +: 64];
      end
      m_instret = m_instret + 64'(cnt);
      if (cnt > TD - trace_q.size()) m_ovf = 1'b1;
      else
         for (int i = 0; i < CW; i++)
            if (commit_valid[i]) trace_q.push_back(commit_pc[i*64 +: 64]);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      clear_commit();
      reset = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      logic [63:0] got, e;
      reset = 1'b0;
      clear_commit();
      rd_addr = '0;
`ifdef RETIRE_TRACE_EN
      trace_ready = 1'b1;
`endif
      model_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if (instret !== 64'd0) begin
         n_fail++; $display("FAIL reset_instret_held got=%h exp=0", instret);
      end
      reset = 1'b1;
      for (int round = 0; round < 4; round++) begin
         for (int p = 0; p < RP; p++) begin
            rd_addr[p*5 +: 5] = 5'(round*RP + p);
            exp_q.push_back(model_read(rd_addr[p*5 +: 5]));
         end
         #1;
         for (int p = 0; p < RP; p++) begin
            got = rd_data[p*64 +: 64];
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
               n_fail++; $display("FAIL reset_read x%0d got=%h exp=%h", round*RP + p, got, e);
            end
         end
         @(negedge clk);
      end
      n_checks++;
      if (instret !== 64'd0) begin
         n_fail++; $display("FAIL reset_instret got=%h exp=0", instret);
      end
`ifdef RETIRE_TRACE_EN
      n_checks++;
      if (trace_valid !== 1'b0 || trace_overflow !== 1'b0) begin
         n_fail++; $display("FAIL reset_trace valid=%b ovf=%b exp=0/0", trace_valid, trace_overflow);
      end
`endif
   endtask

   task automatic test_same_rd();
      logic [63:0] got, e;
      @(negedge clk);
      clear_commit();
      set_lane(0, 5'd5, 64'h1111, 1'b1, 64'h100);
      set_lane(3, 5'd5, 64'h3333, 1'b1, 64'h104);
      for (int p = 0; p < RP; p++) rd_addr[p*5 +: 5] = 5'(p + 3);
      for (int p = 0; p < RP; p++) exp_q.push_back(model_read(rd_addr[p*5 +: 5]));
      #1;
      for (int p = 0; p < RP; p++) begin
         got = rd_data[p*64 +: 64];
         e = exp_q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++; $display("FAIL same_rd_bypass port%0d got=%h exp=%h", p, got, e);
         end
      end
      n_checks++;
      if (rd_data[2*64 +: 64] !== 64'h3333) begin
         n_fail++; $display("FAIL same_rd_bypass_x5 got=%h exp=3333", rd_data[2*64 +: 64]);
      end
      model_commit();
      @(negedge clk);
      clear_commit();
      #1;
      n_checks++;
      if (rd_data[2*64 +: 64] !== 64'h3333) begin
         n_fail++; $display("FAIL same_rd_rf_x5 got=%h exp=3333", rd_data[2*64 +: 64]);
      end
      n_checks++;
      if (instret !== m_instret) begin
         n_fail++; $display("FAIL same_rd_instret got=%h exp=%h", instret, m_instret);
      end
   endtask

   task automatic test_x0();
      @(negedge clk);
      clear_commit();
      set_lane(1, 5'd0, 64'hDEAD, 1'b1, 64'h200);
      rd_addr = '0;
      #1;
      n_checks++;
      if (rd_data[63:0] !== 64'd0) begin
         n_fail++; $display("FAIL x0_bypass got=%h exp=0", rd_data[63:0]);
      end
      model_commit();
      @(negedge clk);
      clear_commit();
      #1;
      n_checks++;
      if (rd_data[63:0] !== 64'd0) begin
         n_fail++; $display("FAIL x0_rf got=%h exp=0", rd_data[63:0]);
      end
      n_checks++;
      if (instret !== m_instret) begin
         n_fail++; $display("FAIL x0_instret got=%h exp=%h", instret, m_instret);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] got, e;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         clear_commit();
         for (int l = 0; l < CW; l++)
            if ($urandom_range(0, 3) != 0)
               set_lane(l, 5'($urandom_range(0, 7)), {$urandom, $urandom},
                        1'($urandom_range(0, 1)), 64'h4000 + 64'(c*CW + l));
         for (int p = 0; p < RP; p++) begin
            rd_addr[p*5 +: 5] = 5'($urandom_range(0, 7));
            exp_q.push_back(model_read(rd_addr[p*5 +: 5]));
         end
         #1;
         for (int p = 0; p < RP; p++) begin
            got = rd_data[p*64 +: 64];
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
               n_fail++; $display("FAIL b2b_read cyc%0d port%0d got=%h exp=%h", c, p, got, e);
            end
         end
         n_checks++;
         if (instret !== m_instret) begin
            n_fail++; $display("FAIL b2b_instret cyc%0d got=%h exp=%h", c, instret, m_instret);
         end
         model_commit();
`ifdef RETIRE_TRACE_EN
         if (trace_valid === 1'b1 && trace_q.size() != 0) void'(trace_q.pop_front());
`endif
      end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      clear_commit();
      force dut.instret = 64'hFFFF_FFFF_FFFF_FFFE;
      #1;
      release dut.instret;
      for (int l = 0; l < CW; l++) set_lane(l, 5'd0, 64'd0, 1'b0, 64'h300);
      @(negedge clk);
      clear_commit();
      #1;
      n_checks++;
      if (instret !== 64'h2) begin
         n_fail++; $display("FAIL instret_wrap got=%h exp=2", instret);
      end
      m_instret = 64'h2;
   endtask

`ifdef RETIRE_TRACE_EN
   task automatic test_trace();
      int budget;
      logic [63:0] e;
      apply_reset();
      trace_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         clear_commit();
         for (int l = 0; l < CW; l++) set_lane(l, 5'd0, 64'd0, 1'b0, 64'h8000_0000 + 64'((c*CW + l)*4));
         model_commit();
      end
      @(negedge clk);
      clear_commit();
      set_lane(2, 5'd0, 64'd0, 1'b0, 64'hBAD0);
      #1;
      n_checks++;
      if (trace_valid !== 1'b1 || trace_overflow !== 1'b0 || trace_pc !== trace_q[0]) begin
         n_fail++; $display("FAIL trace_full valid=%b ovf=%b pc=%h exp=1/0/%h",
                            trace_valid, trace_overflow, trace_pc, trace_q[0]);
      end
      model_commit();
      @(negedge clk);
      clear_commit();
      #1;
      n_checks++;
      if (trace_overflow !== m_ovf) begin
         n_fail++; $display("FAIL trace_overflow got=%b exp=%b", trace_overflow, m_ovf);
      end
      trace_ready = 1'b1;
      budget = 40;
      while (trace_q.size() != 0 && budget > 0) begin
         e = trace_q.pop_front();
         n_checks++;
         if (trace_valid !== 1'b1 || trace_pc !== e) begin
            n_fail++; $display("FAIL trace_drain valid=%b pc=%h exp=1/%h", trace_valid, trace_pc, e);
         end
         @(negedge clk);
         #1;
         budget--;
      end
      n_checks++;
      if (budget == 0 || trace_valid !== 1'b0 || trace_overflow !== 1'b1) begin
         n_fail++; $display("FAIL trace_empty budget=%0d valid=%b ovf=%b exp=0/1", budget, trace_valid, trace_overflow);
      end
   endtask
`endif

   task automatic test_reset_mid();
      @(negedge clk);
`ifdef RETIRE_TRACE_EN
      trace_ready = 1'b0;
      trace_q.delete();
`endif
      for (int c = 0; c < 2; c++) begin
         clear_commit();
         for (int l = 0; l < 4 - c; l++)
            set_lane(l, 5'(1 + c*4 + l), 64'hA000 + 64'(c*4 + l), 1'b1, 64'h9000 + 64'(c*4 + l));
         model_commit();
         @(negedge clk);
      end
      clear_commit();
      for (int p = 0; p < RP; p++) rd_addr[p*5 +: 5] = 5'(p + 1);
      #1;
      n_checks++;
      if (rd_data[2*64 +: 64] !== m_rf[3]) begin
         n_fail++; $display("FAIL mid_prefill x3 got=%h exp=%h", rd_data[2*64 +: 64], m_rf[3]);
      end
`ifdef RETIRE_TRACE_EN
      n_checks++;
      if (trace_valid !== 1'b1) begin
         n_fail++; $display("FAIL mid_prefill_trace got=%b exp=1", trace_valid);
      end
`endif
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (instret !== 64'd0) begin
         n_fail++; $display("FAIL mid_reset_instret got=%h exp=0", instret);
      end
      for (int p = 0; p < RP; p++) begin
         n_checks++;
         if (rd_data[p*64 +: 64] !== 64'd0) begin
            n_fail++; $display("FAIL mid_reset_read x%0d got=%h exp=0", p + 1, rd_data[p*64 +: 64]);
         end
      end
`ifdef RETIRE_TRACE_EN
      n_checks++;
      if (trace_valid !== 1'b0 || trace_overflow !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_trace valid=%b ovf=%b exp=0/0", trace_valid, trace_overflow);
      end
`endif
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      n_checks++;
      if (rd_data[0 +: 64] !== 64'd0 || instret !== 64'd0) begin
         n_fail++; $display("FAIL post_reset x1=%h instret=%h exp=0/0", rd_data[0 +: 64], instret);
      end
   endtask

   initial begin
      test_reset();
      test_same_rd();
      test_x0();
      test_back_to_back();
      test_wrap();
`ifdef RETIRE_TRACE_EN
      test_trace();
`endif
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
